fix_tx_msg_fifo: RTL and testbench
==================================

// Module: fix_tx_msg_fifo
// PURPOSE
//  Store-and-forward byte FIFO between fix_engine's transmit output (message_o /
//  send_message_valid_o) and the TOE transmit interface. Finds each FIX message end
//  (SOH that terminates the "10=" checksum field) and releases only complete messages
//  downstream, tagging the last byte. A message that overflows is rolled back and discarded whole.
// PARAMETERS
//  DEPTH   256    byte entries, power of 2, >= 4
//  AW      8      log2(DEPTH)
//  SOH     8'h01  field delimiter byte
// PORTS
//  clk          in   1     clock, all logic on rising edge
//  rst          in   1     asynchronous active-low reset (0 = reset)
//  flush_i      in   1     sync clear, driven from fix_engine disconnect_o
//  wr_valid_i   in   1     byte strobe, from fix_engine send_message_valid_o
//  wr_data_i    in   8     byte, from fix_engine message_o
//  tx_ready_i   in   1     TOE accepts byte
//  tx_valid_o   out  1     byte of a complete message available
//  tx_data_o    out  8     byte at read head
//  tx_last_o    out  1     head byte is final SOH of its message
//  msg_count_o  out  AW+1  complete messages stored
//  overflow_o   out  1     1-cycle pulse: message discarded on overflow
// BEHAVIOUR
//  Reset (rst=0): all pointers, counts and FSM cleared; state FS; every output 0
//   (tx_data_o 8'h00). Reset mid-message discards all contents. flush_i=1 has the same
//   effect on the next edge and outranks every same-cycle write or read.
//  Storage: 9-bit entries {last,byte}; rd_ptr, wr_ptr, commit_ptr each AW+1 bits, so a
//   full buffer is distinguishable from an empty one.
//   full = (wr_ptr - rd_ptr) == DEPTH.
//  Delimiter FSM, one step per accepted byte (c = wr_data_i):
//   FS  (field start): c=='1'->T1; c==SOH->FS; else OT
//   T1: c=='0'->T10; c==SOH->FS; else OT
//   T10: c=='='->CK; c==SOH->FS; else OT
//   CK: c==SOH -> end-of-message (EOM), ->FS; else CK
//   OT: c==SOH->FS; else OT
//   DROP: write nothing; c==SOH with a pending "10=" match -> FS. The FSM also
//    tracks the 10= sub-match while in DROP, so the end of a discarded message is found.
//  Write: if wr_valid_i and not full and not DROP, store {EOM,c} at wr_ptr and
//   increment wr_ptr. On EOM, commit_ptr <= wr_ptr+1 and msg_count increments.
//  Overflow: if wr_valid_i and full, the byte is not stored, wr_ptr <= commit_ptr,
//   overflow_o pulses, and the FSM enters DROP (or FS if that byte itself was EOM).
//  Read: tx_valid_o = (msg_count != 0). tx_data_o and tx_last_o come from mem[rd_ptr]
//   (first-word fall-through). On tx_valid_o & tx_ready_i, rd_ptr increments; if
//   tx_last_o=1, msg_count decrements.
//  Same-cycle EOM write and last-byte pop: msg_count is unchanged.
//  Latency: the EOM byte is written at edge N; tx_valid_o rises after edge N if the
//   buffer held no message before.
//  Read pointer never passes commit_ptr. A write and a read in the same cycle are
//   both honoured; full is evaluated before that cycle's pop.
//  A message longer than DEPTH can never commit. It is always discarded through
//   overflow_o and DROP.
// TESTING
//  1 "8=FIX.4.2|9=5|35=0|10=161|" (|=SOH), tx_ready_i=1 -> tx_valid_o rises the
//    cycle after the final SOH; 26 bytes out in order; tx_last_o only on byte 26;
//    msg_count_o 1 then 0.
//  2 Two back-to-back messages, tx_ready_i=0 -> msg_count_o=2; release ready ->
//    two tx_last_o pulses, count 2->1->0.
//  3 DEPTH=16, one committed 10-byte message, then a 12-byte message ->
//    overflow_o pulses once on the 7th byte; rest dropped; only the 10-byte
//    message is emitted; a following short message passes intact.
//  4 Field "110=5|" and "x10=..|" inside a message -> no EOM; only a real field-start
//    "10=" commits.
//  5 Simultaneous EOM write and last-byte pop with count=1 -> msg_count_o stays 1.
//  6 rst=0 or flush_i mid-message with 2 stored -> all outputs 0, msg_count_o 0;
//    the next full message is emitted normally.

Source files
------------

// File: rtl/fix_tx_msg_fifo.sv
// fix_tx_msg_fifo: store-and-forward byte FIFO between the FIX engine transmit
// output and the TOE transmit side; only complete messages are released.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   flush_i      synchronous clear (engine disconnect), outranks write and read
//   wr_valid_i   incoming byte strobe
//   wr_data_i    incoming byte
//   tx_ready_i   downstream accepts the head byte
//   tx_valid_o   head byte belongs to a complete message
//   tx_data_o    head byte (0 when nothing is releasable)
//   tx_last_o    head byte is the final SOH of its message
//   msg_count_o  number of complete messages stored
//   overflow_o   one-cycle pulse when an in-progress message is discarded
module fix_tx_msg_fifo #(
    parameter int         DEPTH = 256,
    parameter int         AW    = 8,
    parameter logic [7:0] SOH   = 8'h01
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          wr_valid_i,
    input  logic [7:0]    wr_data_i,
    input  logic          tx_ready_i,
    output logic          tx_valid_o,
    output logic [7:0]    tx_data_o,
    output logic          tx_last_o,
    output logic [AW:0]   msg_count_o,
    output logic          overflow_o
);

    localparam logic [7:0]  CH_1     = 8'h31;
    localparam logic [7:0]  CH_0     = 8'h30;
    localparam logic [7:0]  CH_EQ    = 8'h3D;
    localparam logic [AW:0] FULL_GAP = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    // Field tracker: where we are inside the current tag=value field.
    // It keeps running while a message is being dropped so that the end
    // of the discarded message is still recognised.
    typedef enum logic [2:0] {
        FS,
        T1,
        T10,
        CK,
        OT
    } state_t;

    state_t      state;
    state_t      state_d;
    logic        drop;
    logic        drop_d;

    logic [8:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] commit_ptr;
    logic [AW:0] count;

    logic [8:0]  head;
    logic        full;
    logic        is_soh;
    logic        eom;
    logic        wr_en;
    logic        ovf;
    logic        commit;
    logic        pop;
    logic        pop_last;

    assign head   = mem[rd_ptr[AW-1:0]];
    assign full   = (wr_ptr - rd_ptr) == FULL_GAP;
    assign is_soh = (wr_data_i == SOH);

    assign tx_valid_o  = (count != '0);
    // Memory is not reset, so the head is masked until a message exists.
    assign tx_data_o   = tx_valid_o ? head[7:0] : 8'h00;
    assign tx_last_o   = tx_valid_o & head[8];
    assign msg_count_o = count;

    // Next tracker state and end-of-message detection.
    always_comb begin
        state_d = state;
        eom     = 1'b0;
        if (wr_valid_i) begin
            if (is_soh) begin
                eom     = (state == CK);
                state_d = FS;
            end else begin
                unique case (state)
                    FS:      state_d = (wr_data_i == CH_1)  ? T1  : OT;
                    T1:      state_d = (wr_data_i == CH_0)  ? T10 : OT;
                    T10:     state_d = (wr_data_i == CH_EQ) ? CK  : OT;
                    CK:      state_d = CK;
                    default: state_d = OT;
                endcase
            end
        end
    end

    // Write / overflow / read control.
    always_comb begin
        wr_en    = wr_valid_i & ~full & ~drop;
        ovf      = wr_valid_i &  full & ~drop;
        commit   = wr_en & eom;
        pop      = tx_valid_o & tx_ready_i;
        pop_last = pop & head[8];
        drop_d   = drop;
        if (ovf) begin
            // An overflowing EOM byte ends the message it discards.
            drop_d = ~eom;
        end else if (drop && wr_valid_i && eom) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FS;
            drop       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            commit_ptr <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else if (flush_i) begin
            state      <= FS;
            drop       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            commit_ptr <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            state      <= state_d;
            drop       <= drop_d;
            overflow_o <= ovf;

            // Overflow rolls the partial message back to the last commit.
            if (ovf) begin
                wr_ptr <= commit_ptr;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + ONE;
            end

            if (commit) begin
                commit_ptr <= wr_ptr + ONE;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + ONE;
            end

            unique case ({commit, pop_last})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage carries the last-byte flag next to each byte.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {eom, wr_data_i};
        end
    end

endmodule

// File: tb/tb_fix_tx_msg_fifo.sv
// tb_fix_tx_msg_fifo: self-checking bench for fix_tx_msg_fifo.
// Two instances (DEPTH 256 and DEPTH 16) see identical stimulus.
module tb_fix_tx_msg_fifo;

    localparam logic [7:0] SOH  = 8'h01;
    localparam logic [7:0] C1   = 8'h31;
    localparam logic [7:0] C0   = 8'h30;
    localparam logic [7:0] CEQ  = 8'h3D;
    localparam logic [7:0] CX   = 8'h78;
    localparam logic [7:0] BAR  = 8'h7C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       flush;
    logic       wv;
    logic [7:0] wd;
    logic       rdy;

    logic       v0, l0, o0, v1, l1, o1;
    logic [7:0] d0, d1;
    logic [8:0] c0;
    logic [4:0] c1;

    fix_tx_msg_fifo #(.DEPTH(256), .AW(8), .SOH(SOH)) u_big (
        .clk(clk), .rst(rst), .flush_i(flush),
        .wr_valid_i(wv), .wr_data_i(wd), .tx_ready_i(rdy),
        .tx_valid_o(v0), .tx_data_o(d0), .tx_last_o(l0),
        .msg_count_o(c0), .overflow_o(o0)
    );

    fix_tx_msg_fifo #(.DEPTH(16), .AW(4), .SOH(SOH)) u_small (
        .clk(clk), .rst(rst), .flush_i(flush),
        .wr_valid_i(wv), .wr_data_i(wd), .tx_ready_i(rdy),
        .tx_valid_o(v1), .tx_data_o(d1), .tx_last_o(l1),
        .msg_count_o(c1), .overflow_o(o1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: committed bytes, bytes of the message in progress,
    // drop flag, and the first three characters of the current field.
    logic [8:0]  mq [2][$];
    logic [8:0]  pq [2][$];
    bit          mdrop [2];
    bit          movf [2];
    int          flen;
    logic [23:0] fpre;

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        int         ec;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] conv(input byte c);
        return (c == BAR) ? SOH : c;
    endfunction

    function automatic int mcount(input int k);
        int n = 0;
        logic [8:0] e;
        for (int j = 0; j < mq[k].size(); j++) begin
            e = mq[k][j];
            if (e[8]) n++;
        end
        return n;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            pq[k].delete();
            mdrop[k] = 0;
            movf[k]  = 0;
        end
        flen = 0;
        fpre = '0;
    endtask

    task automatic mstep(input int k, input bit eom);
        int dep;
        bit pop;
        dep = (k == 0) ? 256 : 16;
        movf[k] = 0;
        if (flush) begin
            mq[k].delete();
            pq[k].delete();
            mdrop[k] = 0;
            return;
        end
        pop = (mcount(k) != 0) && rdy;
        if (wv) begin
            if (mdrop[k]) begin
                if (eom) mdrop[k] = 0;
            end else if (mq[k].size() + pq[k].size() == dep) begin
                movf[k] = 1;
                pq[k].delete();
                mdrop[k] = !eom;
            end else begin
                pq[k].push_back({eom, wd});
                if (eom) begin
                    for (int j = 0; j < pq[k].size(); j++)
                        mq[k].push_back(pq[k][j]);
                    pq[k].delete();
                end
            end
        end
        if (pop) void'(mq[k].pop_front());
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int         ec;
            bit         ev;
            logic [8:0] h;
            ec = mcount(k);
            ev = (ec != 0);
            h  = ev ? mq[k][0] : 9'h000;
            chk($sformatf("u%0d.valid", k), int'(k == 0 ? v0 : v1), int'(ev));
            chk($sformatf("u%0d.data", k), int'(k == 0 ? d0 : d1), int'(h[7:0]));
            chk($sformatf("u%0d.last", k), int'(k == 0 ? l0 : l1), int'(h[8]));
            chk($sformatf("u%0d.count", k), (k == 0) ? int'(c0) : int'(c1), ec);
            chk($sformatf("u%0d.ovf", k), int'(k == 0 ? o0 : o1), int'(movf[k]));
        end
    endtask

    task automatic tick();
        bit eom;
        @(posedge clk);
        eom = wv && (wd == SOH) && (flen >= 3) && (fpre == {C1, C0, CEQ});
        mstep(0, eom);
        mstep(1, eom);
        if (flush) begin
            flen = 0;
            fpre = '0;
        end else if (wv) begin
            if (wd == SOH) begin
                flen = 0;
                fpre = '0;
            end else if (flen < 3) begin
                fpre = {fpre[15:0], wd};
                flen++;
            end
        end
        #1;
        check_all();
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_v0"}, int'(v0), 0);
        chk({nm, "_d0"}, int'(d0), 0);
        chk({nm, "_l0"}, int'(l0), 0);
        chk({nm, "_c0"}, int'(c0), 0);
        chk({nm, "_o0"}, int'(o0), 0);
        chk({nm, "_v1"}, int'(v1), 0);
        chk({nm, "_d1"}, int'(d1), 0);
        chk({nm, "_l1"}, int'(l1), 0);
        chk({nm, "_c1"}, int'(c1), 0);
        chk({nm, "_o1"}, int'(o1), 0);
    endtask

    task automatic send(input string s, input bit r);
        for (int i = 0; i < s.len(); i++) begin
            wv  = 1'b1;
            wd  = conv(s[i]);
            rdy = r;
            tick();
        end
        wv = 1'b0;
        wd = 8'h00;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            rdy = 1'b1;
            tick();
        end
        rdy = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic row(input logic w, input logic [7:0] d, input logic r,
                       input logic ev, input logic [7:0] ed,
                       input logic el, input int ec);
        vec_t v;
        v.w = w; v.d = d; v.r = r;
        v.ev = ev; v.ed = ed; v.el = el; v.ec = ec;
        vq.push_back(v);
    endtask

    initial begin
        string s;
        int    n;
        int    nl;
        int    oidx;
        int    op;

        rst = 1'b0; flush = 1'b0; wv = 1'b0; wd = 8'h00; rdy = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;

        // Vector table: "10=1|" stored, then "10=2|" written while the
        // first drains (EOM and last pop coincide), then a message with
        // decoy "110=" and "x10=" fields, then partial drain.
        row(1, C1,  0, 0, 8'h00, 0, 0);
        row(1, C0,  0, 0, 8'h00, 0, 0);
        row(1, CEQ, 0, 0, 8'h00, 0, 0);
        row(1, C1,  0, 0, 8'h00, 0, 0);
        row(1, SOH, 0, 1, C1,    0, 1);
        row(1, C1,  1, 1, C0,    0, 1);
        row(1, C0,  1, 1, CEQ,   0, 1);
        row(1, CEQ, 1, 1, C1,    0, 1);
        row(1, 8'h32, 1, 1, SOH, 1, 1);
        row(1, SOH, 1, 1, C1,    0, 1);
        row(0, 8'h00, 0, 1, C1,  0, 1);
        s = "110=5|x10=|10=|";
        for (int i = 0; i < s.len(); i++)
            row(1, conv(s[i]), 0, 1, C1, 0, (i == s.len() - 1) ? 2 : 1);
        row(0, 8'h00, 1, 1, C0,    0, 2);
        row(0, 8'h00, 1, 1, CEQ,   0, 2);
        row(0, 8'h00, 1, 1, 8'h32, 0, 2);
        row(0, 8'h00, 1, 1, SOH,   1, 2);
        row(0, 8'h00, 1, 1, C1,    0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            wv  = vq[i].w;
            wd  = vq[i].d;
            rdy = vq[i].r;
            tick();
            chk($sformatf("vec%0d_valid", i), int'(v0), int'(vq[i].ev));
            chk($sformatf("vec%0d_data", i), int'(d0), int'(vq[i].ed));
            chk($sformatf("vec%0d_last", i), int'(l0), int'(vq[i].el));
            chk($sformatf("vec%0d_count", i), int'(c0), vq[i].ec);
        end
        wv = 1'b0; rdy = 1'b0;
        do_flush();

        // Single message, ready held high.
        s = "8=FIX.4.2|9=5|35=0|10=161|";
        send(s.substr(0, 24), 1'b1);
        chk("t1_valid_before_eom", int'(v0), 0);
        send("|", 1'b1);
        chk("t1_valid_after_eom", int'(v0), 1);
        chk("t1_count", int'(c0), 1);
        n = 0;
        nl = 0;
        for (int t = 0; t < 40 && v0; t++) begin
            rdy = 1'b1;
            if (n < 26) begin
                chk($sformatf("t1_byte%0d", n), int'(d0), int'(conv(s[n])));
                chk($sformatf("t1_last%0d", n), int'(l0), int'(n == 25));
            end
            if (l0) nl++;
            n++;
            tick();
        end
        rdy = 1'b0;
        chk("t1_nbytes", n, 26);
        chk("t1_nlast", nl, 1);
        chk("t1_small_count", int'(c1), 0);

        // Two back-to-back messages held, then released.
        do_flush();
        send("35=0|10=1|", 1'b0);
        send("9=5|10=22|", 1'b0);
        chk("t2_count", int'(c0), 2);
        nl = 0;
        for (int t = 0; t < 40 && c0 != 0; t++) begin
            rdy = 1'b1;
            if (v0 && l0) nl++;
            tick();
        end
        rdy = 1'b0;
        chk("t2_last_pulses", nl, 2);
        chk("t2_count_end", int'(c0), 0);

        // Overflow on the 16-entry instance.
        do_flush();
        send("35=A|10=1|", 1'b0);
        s = "9=ABC|10=77|";
        oidx = 0;
        op = 0;
        for (int i = 0; i < s.len(); i++) begin
            wv = 1'b1;
            wd = conv(s[i]);
            rdy = 1'b0;
            tick();
            if (o1) begin
                op++;
                if (oidx == 0) oidx = i + 1;
            end
        end
        wv = 1'b0;
        chk("t3_ovf_byte", oidx, 7);
        chk("t3_ovf_pulses", op, 1);
        chk("t3_small_count", int'(c1), 1);
        n = 0;
        for (int t = 0; t < 30; t++) begin
            rdy = 1'b1;
            if (v1) n++;
            tick();
        end
        chk("t3_small_bytes", n, 10);
        rdy = 1'b0;
        send("10=5|", 1'b0);
        chk("t3_after_count", int'(c1), 1);
        n = 0;
        for (int t = 0; t < 10; t++) begin
            rdy = 1'b1;
            if (v1) n++;
            tick();
        end
        rdy = 1'b0;
        chk("t3_after_bytes", n, 5);

        // Asynchronous reset mid-message with two stored.
        do_flush();
        send("A=1|10=2|", 1'b0);
        send("A=1|10=2|", 1'b0);
        send("B=3|1", 1'b0);
        chk("t6_count_before", int'(c0), 2);
        rst = 1'b0;
        #2;
        check_zero("t6_rst_async");
        model_clear();
        @(posedge clk);
        #1;
        check_zero("t6_rst_held");
        rst = 1'b1;
        send("8=X|10=0|", 1'b1);
        drain(20);

        // Flush mid-message, colliding with a write and a read.
        send("A=1|10=2|", 1'b0);
        send("A=1|10=2|", 1'b0);
        send("B=3|1", 1'b0);
        flush = 1'b1; wv = 1'b1; wd = C0; rdy = 1'b1;
        tick();
        flush = 1'b0; wv = 1'b0; rdy = 1'b0;
        check_zero("t6_flush");
        send("8=X|10=0|", 1'b0);
        chk("t6_flush_next", int'(c0), 1);
        drain(20);

        // Randomised traffic against the model.
        for (int t = 0; t < 4000; t++) begin
            int r;
            flush = ($urandom_range(0, 299) == 0);
            wv    = ($urandom_range(0, 3) != 0);
            r     = $urandom_range(0, 99);
            wd    = (r < 20) ? SOH : (r < 45) ? C1 : (r < 65) ? C0 :
                    (r < 85) ? CEQ : CX;
            rdy   = (((t / 400) % 2) == 0) ? ($urandom_range(0, 2) != 0)
                                           : ($urandom_range(0, 5) == 0);
            tick();
        end
        flush = 1'b0; wv = 1'b0;
        drain(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
